io_port_arbiter: RTL and testbench

Two-master, one-slave arbiter for the 8-bit I/O port bus using classic cyc/stb/ack handshakes. Master 0 is the core's port interface; master 1 is a secondary requester such as a debug or DMA engine. The block sits between both masters and the shared peripheral port bus. It grants one master at a time, keeps the bus locked for the full cyc cycle, and ends stalled transfers with a timeout error.

---
 rtl/io_port_arbiter.sv | 166 ++++++++++++++++
 tb/tb_io_port_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_arbiter.sv
// Two-master / one-slave arbiter for the 8-bit I/O port bus (cyc/stb/ack).
// Ports: clk, rst (sync, active-high); m0_*/m1_* master sides (cyc, stb, we,
// adr, dat in; dat, ack, err out); s_* slave side; grant_o one-hot, busy_o.
module io_port_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15,
    parameter int RR      = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    input  logic              m0_we_i,
    input  logic [ADDR_W-1:0] m0_adr_i,
    input  logic [DATA_W-1:0] m0_dat_i,
    output logic [DATA_W-1:0] m0_dat_o,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    input  logic              m1_we_i,
    input  logic [ADDR_W-1:0] m1_adr_i,
    input  logic [DATA_W-1:0] m1_dat_i,
    output logic [DATA_W-1:0] m1_dat_o,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    output logic              s_we_o,
    output logic [ADDR_W-1:0] s_adr_o,
    output logic [DATA_W-1:0] s_dat_o,
    input  logic [DATA_W-1:0] s_dat_i,
    input  logic              s_ack_i,
    output logic [1:0]        grant_o,
    output logic              busy_o
);

    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_LAST =
        CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1, ERR} state_t;

    state_t           state_q, state_d;
    logic             last_grant_q, last_grant_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             req0, req1, stall, timeout_hit;

    assign req0 = m0_cyc_i & m0_stb_i;
    assign req1 = m1_cyc_i & m1_stb_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            stall_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    // Stalled cycle: granted master strobing with no ack this cycle.
    always_comb begin
        stall = 1'b0;
        unique case (state_q)
            GNT0:    stall = m0_stb_i & ~s_ack_i;
            GNT1:    stall = m1_stb_i & ~s_ack_i;
            default: stall = 1'b0;
        endcase
    end

    // Fires on the stalled cycle that brings the count to TIMEOUT.
    assign timeout_hit = (TIMEOUT > 0) && stall &&
                         (stall_cnt_q == TO_LAST);

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    if (RR != 0 && !last_grant_q) state_d = GNT1;
                    else                          state_d = GNT0;
                end else if (req0) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    last_grant_d = 1'b0;
                    state_d      = req1 ? GNT1 : IDLE;
                end else if (timeout_hit) begin
                    last_grant_d = 1'b0;
                    state_d      = ERR;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    last_grant_d = 1'b1;
                    state_d      = req0 ? GNT0 : IDLE;
                end else if (timeout_hit) begin
                    last_grant_d = 1'b1;
                    state_d      = ERR;
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Any state change (release, handoff, error) restarts the count.
    always_comb begin
        stall_cnt_d = '0;
        if (stall && (TIMEOUT > 0)) stall_cnt_d = stall_cnt_q + 1'b1;
        if (state_d != state_q)     stall_cnt_d = '0;
    end

    always_comb begin
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        s_we_o   = 1'b0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        unique case (state_q)
            GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i & m0_stb_i;
                m0_dat_o = s_dat_i;
            end
            GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i & m1_stb_i;
                m1_dat_o = s_dat_i;
            end
            // last_grant already names the master that timed out.
            ERR: begin
                m0_err_o = ~last_grant_q;
                m1_err_o = last_grant_q;
            end
            default: ;
        endcase
    end

    assign grant_o = {state_q == GNT1, state_q == GNT0};
    assign busy_o  = grant_o[0] | grant_o[1];

endmodule

// File: tb/tb_io_port_arbiter.sv
// Directed bench for io_port_arbiter: dut_a (RR=1, TIMEOUT=4) and dut_b
// (RR=0, TIMEOUT=15) share stimulus; read data goes through a scoreboard.
module tb_io_port_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       m0_cyc, m0_stb, m0_we;
    logic [7:0] m0_adr, m0_dat;
    logic       m1_cyc, m1_stb, m1_we;
    logic [7:0] m1_adr, m1_dat;
    logic [7:0] s_dat;
    logic       s_ack;

    logic [7:0] m0_dat_a, m1_dat_a, s_adr_a, s_dat_a;
    logic       m0_ack_a, m0_err_a, m1_ack_a, m1_err_a;
    logic       s_cyc_a, s_stb_a, s_we_a, busy_a;
    logic [1:0] grant_a;

    logic [7:0] m0_dat_b, m1_dat_b, s_adr_b, s_dat_b;
    logic       m0_ack_b, m0_err_b, m1_ack_b, m1_err_b;
    logic       s_cyc_b, s_stb_b, s_we_b, busy_b;
    logic [1:0] grant_b;

    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] q0[$];
    logic [7:0] q1[$];

    always #5 clk = ~clk;

    io_port_arbiter #(.TIMEOUT(4), .RR(1)) dut_a (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_a),
        .m0_ack_o(m0_ack_a), .m0_err_o(m0_err_a),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_a),
        .m1_ack_o(m1_ack_a), .m1_err_o(m1_err_a),
        .s_cyc_o(s_cyc_a), .s_stb_o(s_stb_a), .s_we_o(s_we_a),
        .s_adr_o(s_adr_a), .s_dat_o(s_dat_a), .s_dat_i(s_dat),
        .s_ack_i(s_ack), .grant_o(grant_a), .busy_o(busy_a)
    );

    io_port_arbiter #(.TIMEOUT(15), .RR(0)) dut_b (
        .clk(clk), .rst(rst),
        .m0_cyc_i(m0_cyc), .m0_stb_i(m0_stb), .m0_we_i(m0_we),
        .m0_adr_i(m0_adr), .m0_dat_i(m0_dat), .m0_dat_o(m0_dat_b),
        .m0_ack_o(m0_ack_b), .m0_err_o(m0_err_b),
        .m1_cyc_i(m1_cyc), .m1_stb_i(m1_stb), .m1_we_i(m1_we),
        .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_dat_o(m1_dat_b),
        .m1_ack_o(m1_ack_b), .m1_err_o(m1_err_b),
        .s_cyc_o(s_cyc_b), .s_stb_o(s_stb_b), .s_we_o(s_we_b),
        .s_adr_o(s_adr_b), .s_dat_o(s_dat_b), .s_dat_i(s_dat),
        .s_ack_i(s_ack), .grant_o(grant_b), .busy_o(busy_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic c0, input logic s0,
                       input logic c1, input logic s1);
        m0_cyc = c0;
        m0_stb = s0;
        m1_cyc = c1;
        m1_stb = s1;
    endtask

    task automatic sack(input logic a, input logic [7:0] d);
        s_ack = a;
        s_dat = d;
    endtask

    // Scoreboard consumer: every master ack on dut_a pops one expected word.
    always @(negedge clk) begin
        if (!rst) begin
            if (m0_ack_a) begin
                if (q0.size() == 0) chk("m0_ack_unexp", 32'(m0_ack_a), 0);
                else chk("m0_rdat", 32'(m0_dat_a), 32'(q0.pop_front()));
            end
            if (m1_ack_a) begin
                if (q1.size() == 0) chk("m1_ack_unexp", 32'(m1_ack_a), 0);
                else chk("m1_rdat", 32'(m1_dat_a), 32'(q1.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1;
        req(0, 0, 0, 0);
        m0_we = 0; m0_adr = 0; m0_dat = 0;
        m1_we = 0; m1_adr = 0; m1_dat = 0;
        sack(0, 8'h00);
        tick();
        tick();
        @(negedge clk);
        chk("rst_grant_a", 32'(grant_a), 0);
        chk("rst_busy_a", 32'(busy_a), 0);
        chk("rst_scyc_a", 32'(s_cyc_a), 0);
        chk("rst_sstb_a", 32'(s_stb_a), 0);
        chk("rst_err_a", 32'({m1_err_a, m0_err_a}), 0);
        chk("rst_grant_b", 32'(grant_b), 0);
        tick();
        rst = 1'b0;

        // m0 write, slave acks two cycles after strobe
        m0_we = 1; m0_adr = 8'h10; m0_dat = 8'hA5;
        req(1, 1, 0, 0);
        @(negedge clk);
        chk("wr_pre_grant", 32'(grant_a), 0);
        chk("wr_pre_scyc", 32'(s_cyc_a), 0);
        tick();
        @(negedge clk);
        chk("wr_grant", 32'(grant_a), 1);
        chk("wr_scyc", 32'(s_cyc_a), 1);
        chk("wr_sadr", 32'(s_adr_a), 32'h10);
        chk("wr_sdat", 32'(s_dat_a), 32'hA5);
        chk("wr_swe", 32'(s_we_a), 1);
        chk("wr_ack_early", 32'(m0_ack_a), 0);
        tick();
        @(negedge clk);
        chk("wr_ack_wait", 32'(m0_ack_a), 0);
        tick();
        sack(1, 8'h00);
        q0.push_back(8'h00);
        @(negedge clk);
        chk("wr_ack", 32'(m0_ack_a), 1);
        chk("wr_m1_ack", 32'(m1_ack_a), 0);
        tick();
        sack(0, 8'h00);
        req(0, 0, 0, 0);
        m0_we = 0;
        @(negedge clk);
        chk("wr_ack_once", 32'(m0_ack_a), 0);
        chk("wr_grant_rel", 32'(grant_a), 1);
        tick();
        @(negedge clk);
        chk("wr_idle_grant", 32'(grant_a), 0);
        chk("wr_idle_busy", 32'(busy_a), 0);

        // contention after reset: single reads, zero-wait slave
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m0_adr = 8'h20; m1_adr = 8'h21;
        req(1, 1, 1, 1);
        @(negedge clk);
        chk("rr_c0_grant", 32'(grant_a), 0);
        tick();
        sack(1, 8'hC1);
        q0.push_back(8'hC1);
        @(negedge clk);
        chk("rr_1_grant_a", 32'(grant_a), 1);
        chk("rr_1_grant_b", 32'(grant_b), 1);
        tick();
        sack(0, 8'h00);
        req(0, 0, 1, 1);
        @(negedge clk);
        chk("rr_rel_grant", 32'(grant_a), 1);
        tick();
        sack(1, 8'hC2);
        q1.push_back(8'hC2);
        req(1, 1, 1, 1);
        @(negedge clk);
        chk("rr_2_grant_a", 32'(grant_a), 2);
        chk("rr_2_grant_b", 32'(grant_b), 2);
        chk("rr_2_m0_dat", 32'(m0_dat_a), 0);
        chk("rr_2_m0_ack", 32'(m0_ack_a), 0);
        tick();
        sack(0, 8'h00);
        req(1, 1, 0, 0);
        tick();
        sack(1, 8'hC3);
        q0.push_back(8'hC3);
        req(1, 1, 1, 1);
        @(negedge clk);
        chk("rr_3_grant_a", 32'(grant_a), 1);
        chk("rr_3_grant_b", 32'(grant_b), 1);
        tick();
        sack(0, 8'h00);
        req(0, 0, 0, 0);
        tick();
        req(1, 1, 1, 1);
        @(negedge clk);
        chk("rr_idle_busy", 32'(busy_a), 0);
        tick();
        sack(1, 8'hC4);
        q1.push_back(8'hC4);
        @(negedge clk);
        chk("rr_4_grant_a", 32'(grant_a), 2);
        chk("fx_4_grant_b", 32'(grant_b), 1);
        chk("fx_4_ack_b", 32'(m0_ack_b), 1);
        tick();
        sack(0, 8'h00);
        req(0, 0, 0, 0);
        tick();
        @(negedge clk);
        chk("rr_end_grant", 32'(grant_a), 0);

        // m1 locks the bus for three reads while m0 keeps requesting
        m1_adr = 8'h30;
        req(0, 0, 1, 1);
        tick();
        req(1, 1, 1, 1);
        sack(1, 8'h11);
        q1.push_back(8'h11);
        @(negedge clk);
        chk("lk_grant_1", 32'(grant_a), 2);
        chk("lk_m0_ack", 32'(m0_ack_a), 0);
        chk("lk_m0_dat", 32'(m0_dat_a), 0);
        tick();
        req(1, 1, 1, 0);
        sack(0, 8'h00);
        @(negedge clk);
        chk("lk_gap_grant", 32'(grant_a), 2);
        chk("lk_gap_scyc", 32'(s_cyc_a), 1);
        chk("lk_gap_sstb", 32'(s_stb_a), 0);
        tick();
        req(1, 1, 1, 1);
        sack(1, 8'h22);
        q1.push_back(8'h22);
        @(negedge clk);
        chk("lk_grant_2", 32'(grant_a), 2);
        tick();
        sack(1, 8'h33);
        q1.push_back(8'h33);
        @(negedge clk);
        chk("lk_grant_3b", 32'(grant_b), 2);
        tick();
        req(1, 1, 0, 0);
        sack(0, 8'h00);
        @(negedge clk);
        chk("lk_rel_grant", 32'(grant_a), 2);
        tick();
        sack(1, 8'h44);
        q0.push_back(8'h44);
        @(negedge clk);
        chk("lk_hand_grant_a", 32'(grant_a), 1);
        chk("lk_hand_busy_a", 32'(busy_a), 1);
        chk("lk_hand_grant_b", 32'(grant_b), 1);
        tick();
        sack(0, 8'h00);
        req(0, 0, 0, 0);
        tick();
        @(negedge clk);
        chk("lk_end_busy", 32'(busy_a), 0);

        // stalled transfer on dut_a times out after 4 cycles
        m0_adr = 8'h40;
        req(1, 1, 0, 0);
        tick();
        @(negedge clk);
        chk("to_grant", 32'(grant_a), 1);
        tick();
        tick();
        tick();
        @(negedge clk);
        chk("to_no_err_yet", 32'(m0_err_a), 0);
        chk("to_still_gnt", 32'(grant_a), 1);
        tick();
        sack(1, 8'hEE);
        @(negedge clk);
        chk("to_err_m0", 32'(m0_err_a), 1);
        chk("to_err_m1", 32'(m1_err_a), 0);
        chk("to_err_scyc", 32'(s_cyc_a), 0);
        chk("to_err_sstb", 32'(s_stb_a), 0);
        chk("to_err_grant", 32'(grant_a), 0);
        chk("to_err_busy", 32'(busy_a), 0);
        chk("to_late_ack", 32'(m0_ack_a), 0);
        tick();
        req(0, 0, 0, 0);
        @(negedge clk);
        chk("to_idle_err", 32'(m0_err_a), 0);
        chk("to_idle_ack", 32'(m0_ack_a), 0);
        chk("to_idle_grant", 32'(grant_a), 0);
        tick();
        sack(0, 8'h00);

        // reset while dut is in GNT1
        req(0, 0, 1, 1);
        tick();
        @(negedge clk);
        chk("rs_gnt1", 32'(grant_a), 2);
        tick();
        rst = 1'b1;
        req(1, 1, 1, 1);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rs_grant_a", 32'(grant_a), 0);
        chk("rs_scyc_a", 32'(s_cyc_a), 0);
        chk("rs_busy_a", 32'(busy_a), 0);
        chk("rs_grant_b", 32'(grant_b), 0);
        tick();
        @(negedge clk);
        chk("rs_first_a", 32'(grant_a), 1);
        chk("rs_first_b", 32'(grant_b), 1);
        tick();
        req(0, 0, 0, 0);
        tick();
        tick();

        // m0 drops cyc with its final ack while m1 waits
        m0_adr = 8'h50;
        req(1, 1, 0, 0);
        tick();
        req(1, 1, 1, 1);
        sack(1, 8'h55);
        q0.push_back(8'h55);
        @(negedge clk);
        chk("bb_ack_1", 32'(m0_ack_a), 1);
        tick();
        req(0, 1, 1, 1);
        sack(1, 8'h66);
        q0.push_back(8'h66);
        @(negedge clk);
        chk("bb_ack_last", 32'(m0_ack_a), 1);
        chk("bb_grant_last", 32'(grant_a), 1);
        tick();
        sack(0, 8'h00);
        req(0, 0, 0, 0);
        @(negedge clk);
        chk("bb_grant_a", 32'(grant_a), 2);
        chk("bb_grant_b", 32'(grant_b), 2);
        chk("bb_no_ack", 32'(m0_ack_a), 0);
        tick();
        @(negedge clk);
        chk("bb_end_busy", 32'(busy_a), 0);

        tick();
        @(negedge clk);
        chk("sb_q0_left", 32'(q0.size()), 0);
        chk("sb_q1_left", 32'(q1.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
